// File: rtl/thermocouple_spi_responder.sv
// Thermocouple-to-digital converter device model: periodic snapshot of
// temperature/fault inputs into a 32-bit frame, shifted out MSB-first on SPI.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   sck, cs_n        asynchronous SPI clock / chip select from the master
//   tc_temp_in       14-bit thermocouple temperature (0.25 C/LSB)
//   junction_temp_in 12-bit cold-junction temperature (0.0625 C/LSB)
//   fault_in         {short-to-VCC, short-to-GND, open-circuit}
//   miso, miso_oe    serial data and its drive enable
//   frame_done       one-cycle pulse after the 32nd bit is shifted out
//
// Optional feature macro: TC_ZERO_ON_FAULT_EN (zero the thermocouple
// field of a snapshot taken while any fault bit is set).
module thermocouple_spi_responder #(
    parameter int CONV_CYCLES = 300,
    parameter int CBITS       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sck,
    input  logic        cs_n,
    input  logic [13:0] tc_temp_in,
    input  logic [11:0] junction_temp_in,
    input  logic [2:0]  fault_in,
    output logic        miso,
    output logic        miso_oe,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CBITS-1:0] CONV_LAST = CBITS'(CONV_CYCLES - 1);

    // [0],[1] synchronizer, [2] previous synchronized value
    logic [2:0] sck_sync;
    logic [2:0] cs_sync;

    logic sck_fall;
    logic cs_fall;
    logic cs_rise;

    state_t           state;
    logic [31:0]      shadow;
    logic [31:0]      shreg;
    logic [5:0]       bit_cnt;
    logic [CBITS-1:0] conv_cnt;
    logic [13:0]      tc_field;
    logic [31:0]      frame_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync <= 3'b000;
            cs_sync  <= 3'b111;
        end else begin
            sck_sync <= {sck_sync[1:0], sck};
            cs_sync  <= {cs_sync[1:0], cs_n};
        end
    end

    assign sck_fall = sck_sync[2] & ~sck_sync[1];
    assign cs_fall  = cs_sync[2] & ~cs_sync[1];
    assign cs_rise  = ~cs_sync[2] & cs_sync[1];

    always_comb begin
        tc_field = tc_temp_in;
`ifdef TC_ZERO_ON_FAULT_EN
        if (|fault_in) begin
            tc_field = '0;
        end
`endif
        frame_p = {tc_field, 1'b0, |fault_in,
                   junction_temp_in, 1'b0, fault_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shadow     <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            conv_cnt   <= '0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Conversion time only accrues while deselected;
                    // a select in the snapshot cycle sees the old shadow.
                    if (conv_cnt == CONV_LAST) begin
                        shadow   <= frame_p;
                        conv_cnt <= '0;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                    miso    <= 1'b0;
                    miso_oe <= 1'b0;
                    if (cs_fall) begin
                        shreg   <= shadow;
                        miso    <= shadow[31];
                        miso_oe <= 1'b1;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Deselect has priority over a coincident sck fall.
                    if (cs_rise) begin
                        miso    <= 1'b0;
                        miso_oe <= 1'b0;
                        state   <= IDLE;
                    end else if (sck_fall) begin
                        shreg   <= {shreg[30:0], 1'b0};
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd31) begin
                            miso       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            miso <= shreg[30];
                        end
                    end
                end
                DONE: begin
                    miso <= 1'b0;
                    if (cs_rise) begin
                        miso_oe <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    miso    <= 1'b0;
                    miso_oe <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thermocouple_spi_responder.sv
// Scoreboard bench for thermocouple_spi_responder: an SPI master reads
// frames and a monitor compares them with frames predicted from the inputs.
module tb_thermocouple_spi_responder;

    localparam int CONV = 300;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        cs_n;
    logic [13:0] tc_temp_in;
    logic [11:0] junction_temp_in;
    logic [2:0]  fault_in;
    logic        miso;
    logic        miso_oe;
    logic        frame_done;

    thermocouple_spi_responder #(
        .CONV_CYCLES(CONV),
        .CBITS(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sck(sck),
        .cs_n(cs_n),
        .tc_temp_in(tc_temp_in),
        .junction_temp_in(junction_temp_in),
        .fault_in(fault_in),
        .miso(miso),
        .miso_oe(miso_oe),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        int          ndone;
        logic        oe_in;
        logic        oe_out;
    } txn_t;

    txn_t exp_q[$];
    txn_t got_q[$];

    int checks = 0;
    int errors = 0;
    int bits_rx = 0;
    int done_total = 0;
    logic [31:0] model_frame;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    // Frame as the datasheet describes it: fields weighted by bit position.
    function automatic logic [31:0] pack(input logic [13:0] tc,
                                         input logic [11:0] j,
                                         input logic [2:0] f);
        int unsigned t;
        int unsigned v;
        t = 32'(tc);
`ifdef TC_ZERO_ON_FAULT_EN
        if (f != 3'd0) t = 0;
`endif
        v = t * 262144 + ((f != 3'd0) ? 65536 : 0) + 32'(j) * 16 + 32'(f);
        return v;
    endfunction

    // What a master clocking n bits sees: the frame, then zeros.
    function automatic logic [63:0] exp_bits(input logic [31:0] f,
                                             input int n);
        logic [63:0] w;
        w = {32'b0, f};
        if (n <= 32) return w >> (32 - n);
        return w << (n - 32);
    endfunction

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            done_total++;
            chk("done_after_bit32", 64'(bits_rx), 64'd32);
        end
    end

    initial begin : monitor
        txn_t e;
        txn_t g;
        forever begin
            wait (got_q.size() > 0);
            g = got_q.pop_front();
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty got=%0h expected=none",
                         g.data);
            end else begin
                e = exp_q.pop_front();
                chk("frame_bits", g.data, e.data);
                chk("frame_done_count", 64'(g.ndone), 64'(e.ndone));
                chk("oe_selected", 64'(g.oe_in), 64'(e.oe_in));
                chk("oe_after_cs_rise", 64'(g.oe_out), 64'(e.oe_out));
            end
        end
    end

    task automatic scramble_inputs();
        tc_temp_in       = 14'($urandom);
        junction_temp_in = 12'($urandom);
        fault_in         = 3'($urandom);
    endtask

    task automatic settle(input logic [13:0] tc, input logic [11:0] j,
                          input logic [2:0] f);
        @(negedge clk);
        tc_temp_in       = tc;
        junction_temp_in = j;
        fault_in         = f;
        model_frame      = pack(tc, j, f);
        repeat (CONV + 10) @(negedge clk);
    endtask

    task automatic do_read(input int nbits, input bit scramble);
        txn_t e;
        txn_t g;
        int d0;
        e.data   = exp_bits(model_frame, nbits);
        e.ndone  = (nbits >= 32) ? 1 : 0;
        e.oe_in  = 1'b1;
        e.oe_out = 1'b0;
        exp_q.push_back(e);
        g.data  = '0;
        bits_rx = 0;
        d0      = done_total;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        g.oe_in = miso_oe;
        for (int i = 0; i < nbits; i++) begin
            g.data = {g.data[62:0], miso};
            bits_rx++;
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            if (scramble && i == 4) scramble_inputs();
            sck = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        g.oe_out = miso_oe;
        g.ndone  = done_total - d0;
        got_q.push_back(g);
        repeat (10) @(negedge clk);
    endtask

    task automatic reset_mid_frame();
        bits_rx = 0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        chk("oe_before_rst", 64'(miso_oe), 64'd1);
        rst  = 1'b1;
        cs_n = 1'b1;
        @(negedge clk);
        chk("rst_miso", 64'(miso), 64'd0);
        chk("rst_miso_oe", 64'(miso_oe), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_frame = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin : stimulus
        int n;
        rst              = 1'b1;
        sck              = 1'b0;
        cs_n             = 1'b1;
        tc_temp_in       = '0;
        junction_temp_in = '0;
        fault_in         = '0;
        model_frame      = '0;
        repeat (4) @(negedge clk);
        chk("reset_miso", 64'(miso), 64'd0);
        chk("reset_miso_oe", 64'(miso_oe), 64'd0);
        chk("reset_frame_done", 64'(frame_done), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_read(32, 1'b0);

        settle(14'h0640, 12'h190, 3'b000);
        do_read(32, 1'b0);
        settle(14'h0640, 12'h190, 3'b001);
        do_read(32, 1'b0);
        settle(14'h3FFC, 12'hFF0, 3'b000);
        do_read(32, 1'b0);

        settle(14'($urandom), 12'($urandom), 3'($urandom));
        do_read(32, 1'b1);

        settle(14'($urandom), 12'($urandom), 3'($urandom));
        do_read(10, 1'b0);
        do_read(32, 1'b0);
        do_read(40, 1'b0);

        reset_mid_frame();
        do_read(32, 1'b0);

        for (int k = 0; k < 6; k++) begin
            settle(14'($urandom), 12'($urandom), 3'($urandom));
            n = $urandom_range(1, 40);
            do_read(n, 1'b0);
        end

        for (int k = 0; k < 2000 && got_q.size() > 0; k++) @(negedge clk);
        if (got_q.size() != 0 || exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got=%0d expected=0",
                     got_q.size() + exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
